// File: rtl/pong_video_scanner.sv
// Pong raster generator and pixel compositor: VGA sync, 6-bit tile counters, RGB built from registered draw flags.
// Latency: tile counters 1 clk after the raster counters, consumer flags 2 clks, RGB/sync/frame-start 3 clks.
// Backpressure: none, free-running raster. Optional centre net is built when PONG_CENTER_NET_EN is defined.
module pong_video_scanner #(
    parameter int unsigned c_TOTAL_COLS    = 800,
    parameter int unsigned c_TOTAL_ROWS    = 525,
    parameter int unsigned c_ACTIVE_COLS   = 640,
    parameter int unsigned c_ACTIVE_ROWS   = 480,
    parameter int unsigned c_FRONT_PORCH_H = 16,
    parameter int unsigned c_SYNC_H        = 96,
    parameter int unsigned c_FRONT_PORCH_V = 10,
    parameter int unsigned c_SYNC_V        = 2,
    parameter int unsigned c_TILE_SHIFT    = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Game_On,
    input  logic       i_Draw_Ball,
    input  logic       i_Draw_Paddle_P1,
    input  logic       i_Draw_Paddle_P2,
    output logic [5:0] o_Col_Counter,
    output logic [5:0] o_Row_Counter,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic [2:0] o_Red,
    output logic [2:0] o_Grn,
    output logic [2:0] o_Blu,
    output logic       o_Frame_Start
);

    localparam logic [9:0] c_COL_LAST = 10'(c_TOTAL_COLS - 1);
    localparam logic [9:0] c_ROW_LAST = 10'(c_TOTAL_ROWS - 1);
    localparam logic [9:0] c_ACT_COLS = 10'(c_ACTIVE_COLS);
    localparam logic [9:0] c_ACT_ROWS = 10'(c_ACTIVE_ROWS);
    localparam logic [9:0] c_HS_START = 10'(c_ACTIVE_COLS + c_FRONT_PORCH_H);
    localparam logic [9:0] c_HS_END   = 10'(c_ACTIVE_COLS + c_FRONT_PORCH_H + c_SYNC_H);
    localparam logic [9:0] c_VS_START = 10'(c_ACTIVE_ROWS + c_FRONT_PORCH_V);
    localparam logic [9:0] c_VS_END   = 10'(c_ACTIVE_ROWS + c_FRONT_PORCH_V + c_SYNC_V);

    logic [9:0] r_Col;
    logic [9:0] r_Row;
    logic       r_Active_1, r_HSync_1, r_VSync_1, r_Frame_1;
    logic       r_Active_2, r_HSync_2, r_VSync_2, r_Frame_2;
    logic [2:0] w_Level;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Col <= '0;
            r_Row <= '0;
        end else if (r_Col == c_COL_LAST) begin
            r_Col <= '0;
            r_Row <= (r_Row == c_ROW_LAST) ? '0 : r_Row + 10'd1;
        end else begin
            r_Col <= r_Col + 10'd1;
        end
    end

    // Stage 1: tile coordinates for the consumers plus raw raster flags.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Col_Counter <= '0;
            o_Row_Counter <= '0;
            r_Active_1    <= 1'b0;
            r_HSync_1     <= 1'b1;
            r_VSync_1     <= 1'b1;
            r_Frame_1     <= 1'b0;
        end else begin
            o_Col_Counter <= 6'(r_Col >> c_TILE_SHIFT);
            o_Row_Counter <= 6'(r_Row >> c_TILE_SHIFT);
            r_Active_1    <= (r_Col < c_ACT_COLS) && (r_Row < c_ACT_ROWS);
            r_HSync_1     <= !((r_Col >= c_HS_START) && (r_Col < c_HS_END));
            r_VSync_1     <= !((r_Row >= c_VS_START) && (r_Row < c_VS_END));
            r_Frame_1     <= (r_Col == '0) && (r_Row == '0);
        end
    end

    // Stage 2: wait while the consumers register their draw flags.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Active_2 <= 1'b0;
            r_HSync_2  <= 1'b1;
            r_VSync_2  <= 1'b1;
            r_Frame_2  <= 1'b0;
        end else begin
            r_Active_2 <= r_Active_1;
            r_HSync_2  <= r_HSync_1;
            r_VSync_2  <= r_VSync_1;
            r_Frame_2  <= r_Frame_1;
        end
    end

`ifdef PONG_CENTER_NET_EN
    localparam logic [5:0] c_NET_COL = 6'((c_ACTIVE_COLS >> c_TILE_SHIFT) / 2);

    logic r_Net_2;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Net_2 <= 1'b0;
        end else begin
            r_Net_2 <= (o_Col_Counter == c_NET_COL) && !o_Row_Counter[0];
        end
    end
`endif

    // Ball and paddles share full white, so they collapse into one top-priority term.
    always_comb begin
        w_Level = '0;
        if (r_Active_2) begin
            if ((i_Draw_Ball && i_Game_On) || i_Draw_Paddle_P1 || i_Draw_Paddle_P2) begin
                w_Level = 3'd7;
`ifdef PONG_CENTER_NET_EN
            end else if (r_Net_2) begin
                w_Level = 3'd3;
`endif
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Red         <= '0;
            o_Grn         <= '0;
            o_Blu         <= '0;
            o_HSync       <= 1'b1;
            o_VSync       <= 1'b1;
            o_Frame_Start <= 1'b0;
        end else begin
            o_Red         <= w_Level;
            o_Grn         <= w_Level;
            o_Blu         <= w_Level;
            o_HSync       <= r_HSync_2;
            o_VSync       <= r_VSync_2;
            o_Frame_Start <= r_Frame_2;
        end
    end

endmodule
